// File: rtl/stack_pointer_unit_pkg.sv
// Shared constants for the stack pointer unit: stack operation codes and default geometry.
package stack_pointer_unit_pkg;

  // sigNewSP encodings driven by the control unit during MEM; 2'b11 is reserved and holds.
  localparam logic [1:0] stackPointerDef  = 2'b00;
  localparam logic [1:0] stackPointerPush = 2'b01;
  localparam logic [1:0] stackPointerPop  = 2'b10;

  localparam int unsigned StackAddrWDefault = 16;
  localparam logic [15:0] StackBaseDefault  = 16'hFF00;
  localparam int unsigned StackDepthDefault = 64;

endpackage

// File: rtl/sp_updown_counter.sv
// Saturating up/down counter with hold and registered min/max detect derived from next count.
module sp_updown_counter #(
  parameter int unsigned Width  = 3,
  parameter int unsigned MaxVal = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic [Width-1:0] count_next_o,
  output logic             at_min_o,
  output logic             at_max_o
);

  localparam logic [Width-1:0] MaxCnt = Width'(MaxVal);

  logic [Width-1:0] count_q, count_d;
  logic             at_min_q, at_max_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != MaxCnt)) begin
      count_d = count_q + Width'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      at_min_q <= 1'b1;
      at_max_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      at_min_q <= (count_d == '0);
      at_max_q <= (count_d == MaxCnt);
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign at_min_o     = at_min_q;
  assign at_max_o     = at_max_q;

endmodule

// File: rtl/stack_pointer_unit.sv
// Stack pointer for the multi-cycle core: upward-growing stack, saturating, sticky error bits.
// Optional depth watermark enabled by defining STACK_WATERMARK_EN.
module stack_pointer_unit
  import stack_pointer_unit_pkg::*;
#(
  parameter int unsigned          ADDR_W     = StackAddrWDefault,
  parameter logic [ADDR_W-1:0]    STACK_BASE = ADDR_W'(StackBaseDefault),
  parameter int unsigned          DEPTH      = StackDepthDefault,
  localparam int unsigned         DepthW     = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enMem,
  input  logic [1:0]        sigNewSP,
  output logic [ADDR_W-1:0] stackAddr,
  output logic [ADDR_W-1:0] stackPointer,
  output logic [DepthW-1:0] stackDepth,
  output logic              fullFlag,
  output logic              emptyFlag,
  output logic              overflowErr,
  output logic              underflowErr,
  output logic [DepthW-1:0] highWater
);

  logic              push_req, pop_req;
  logic              inc, dec;
  logic [DepthW-1:0] depth_next;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              ovf_q, unf_q;

  assign push_req = enMem && (sigNewSP == stackPointerPush);
  assign pop_req  = enMem && (sigNewSP == stackPointerPop);
  assign inc      = push_req && !fullFlag;
  assign dec      = pop_req && !emptyFlag;

  sp_updown_counter #(
    .Width  (DepthW),
    .MaxVal (DEPTH)
  ) u_depth (
    .clk_i        (clock),
    .rst_i        (reset),
    .inc_i        (inc),
    .dec_i        (dec),
    .count_o      (stackDepth),
    .count_next_o (depth_next),
    .at_min_o     (emptyFlag),
    .at_max_o     (fullFlag)
  );

  // SP tracks STACK_BASE + depth in lockstep using the same gated inc/dec.
  always_comb begin
    sp_d = sp_q;
    if (inc) begin
      sp_d = sp_q + ADDR_W'(1);
    end else if (dec) begin
      sp_d = sp_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q  <= STACK_BASE;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_q | (push_req && fullFlag);
      unf_q <= unf_q | (pop_req && emptyFlag);
    end
  end

  always_comb begin
    stackAddr = sp_q;
    if (pop_req) begin
      stackAddr = emptyFlag ? STACK_BASE : (sp_q - ADDR_W'(1));
    end
  end

  assign stackPointer = sp_q;
  assign overflowErr  = ovf_q;
  assign underflowErr = unf_q;

`ifdef STACK_WATERMARK_EN
  logic [DepthW-1:0] hw_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hw_q <= '0;
    end else if (depth_next > hw_q) begin
      hw_q <= depth_next;
    end
  end

  assign highWater = hw_q;
`else
  logic unused_depth_next;
  assign unused_depth_next = ^depth_next;
  assign highWater         = '0;
`endif

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit with DEPTH=4, STACK_BASE=16'hFF00.
module tb_stack_pointer_unit;

  localparam int unsigned DepthW = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              enMem;
  logic [1:0]        sigNewSP;
  logic [15:0]       stackAddr;
  logic [15:0]       stackPointer;
  logic [DepthW-1:0] stackDepth;
  logic              fullFlag;
  logic              emptyFlag;
  logic              overflowErr;
  logic              underflowErr;
  logic [DepthW-1:0] highWater;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  stack_pointer_unit #(
    .ADDR_W     (16),
    .STACK_BASE (16'hFF00),
    .DEPTH      (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enMem        (enMem),
    .sigNewSP     (sigNewSP),
    .stackAddr    (stackAddr),
    .stackPointer (stackPointer),
    .stackDepth   (stackDepth),
    .fullFlag     (fullFlag),
    .emptyFlag    (emptyFlag),
    .overflowErr  (overflowErr),
    .underflowErr (underflowErr),
    .highWater    (highWater)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle after a posedge, check the combinational address, then step past the edge.
  task automatic apply(input logic rst, input logic en, input logic [1:0] op,
                       input logic [15:0] exp_addr, input string tag);
    reset    = rst;
    enMem    = en;
    sigNewSP = op;
    #1;
    check_eq({tag, ".addr"}, 32'(stackAddr), 32'(exp_addr));
    @(posedge clock);
    #1;
    reset    = 1'b0;
    enMem    = 1'b0;
    sigNewSP = 2'b00;
  endtask

  task automatic check_state(input string tag, input logic [15:0] sp, input int depth,
                             input logic full, input logic empty, input logic ovf,
                             input logic unf, input int hw);
    check_eq({tag, ".sp"},    32'(stackPointer), 32'(sp));
    check_eq({tag, ".depth"}, 32'(stackDepth),   32'(depth));
    check_eq({tag, ".full"},  32'(fullFlag),     32'(full));
    check_eq({tag, ".empty"}, 32'(emptyFlag),    32'(empty));
    check_eq({tag, ".ovf"},   32'(overflowErr),  32'(ovf));
    check_eq({tag, ".unf"},   32'(underflowErr), 32'(unf));
`ifdef STACK_WATERMARK_EN
    check_eq({tag, ".hw"},    32'(highWater),    32'(hw));
`else
    check_eq({tag, ".hw"},    32'(highWater),    32'(0 * hw));
`endif
  endtask

  localparam logic [1:0] OpDef  = 2'b00;
  localparam logic [1:0] OpPush = 2'b01;
  localparam logic [1:0] OpPop  = 2'b10;
  localparam logic [1:0] OpRsv  = 2'b11;

  initial begin
    reset    = 1'b1;
    enMem    = 1'b0;
    sigNewSP = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // 1. reset then idle
    apply(1'b0, 1'b0, OpDef, 16'hFF00, "idle");
    check_state("reset", 16'hFF00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // 2. fill
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, OpPush, 16'hFF00 + 16'(i), "push");
      if (i == 2) check_state("push3", 16'hFF03, 3, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    end
    check_state("full", 16'hFF04, 4, 1'b1, 1'b0, 1'b0, 1'b0, 4);

    // 3. overflow, then drain
    apply(1'b0, 1'b1, OpPush, 16'hFF04, "push_full");
    check_state("ovf", 16'hFF04, 4, 1'b1, 1'b0, 1'b1, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, OpPop, 16'hFF03 - 16'(i), "pop");
    end
    check_state("drained", 16'hFF00, 0, 1'b0, 1'b1, 1'b1, 1'b0, 4);

    // 4. underflow, disabled op, reserved op
    apply(1'b0, 1'b1, OpPop, 16'hFF00, "pop_empty");
    check_state("unf", 16'hFF00, 0, 1'b0, 1'b1, 1'b1, 1'b1, 4);
    apply(1'b0, 1'b0, OpPush, 16'hFF00, "push_noen");
    check_state("noen", 16'hFF00, 0, 1'b0, 1'b1, 1'b1, 1'b1, 4);
    apply(1'b0, 1'b1, OpRsv, 16'hFF00, "rsv");
    check_state("rsv", 16'hFF00, 0, 1'b0, 1'b1, 1'b1, 1'b1, 4);

    // 5. reset wins over a same-cycle push
    apply(1'b0, 1'b1, OpPush, 16'hFF00, "rpush0");
    apply(1'b0, 1'b1, OpPush, 16'hFF01, "rpush1");
    check_state("pre_rst", 16'hFF02, 2, 1'b0, 1'b0, 1'b1, 1'b1, 4);
    apply(1'b1, 1'b1, OpPush, 16'hFF02, "rst_push");
    check_state("post_rst", 16'hFF00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // 6. watermark
    apply(1'b0, 1'b1, OpPush, 16'hFF00, "wm_push0");
    apply(1'b0, 1'b1, OpPush, 16'hFF01, "wm_push1");
    apply(1'b0, 1'b1, OpPush, 16'hFF02, "wm_push2");
    apply(1'b0, 1'b1, OpPop,  16'hFF02, "wm_pop0");
    apply(1'b0, 1'b1, OpPop,  16'hFF01, "wm_pop1");
    check_state("wm", 16'hFF01, 1, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
